hash_target_check: RTL and testbench
====================================

Name: hash_target_check

Overview:
- Consumes the 256-bit difficulty target from the nBits expansion stage and a stream of double-SHA256 results from the hash core.
- Decides whether each hash meets the target, i.e. hash <= target as unsigned 256-bit integers.
- Compares iteratively, MSB chunk first, and terminates early at the first differing chunk.
- Latches the winning (golden) nonce for the host/UART readout logic.

Parameters:
- CHUNK_W, 32, bits compared per cycle; must divide 256 (elaboration error otherwise).
- CNT_W, 16, width of the saturating found counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- hash_valid  input  1  hash_in/nonce_in valid.
- hash_ready  output  1  block can accept a hash.
- hash_in  input  256  hash result, bit 255 = most significant.
- nonce_in  input  32  nonce that produced hash_in.
- target_in  input  256  expanded target from the target stage.
- clear_found  input  1  one-cycle pulse that clears found.
- result_valid  output  1  one-cycle pulse, comparison finished.
- result_meets  output  1  hash <= target; valid with result_valid.
- found  output  1  sticky, a qualifying hash has been seen.
- golden_nonce  output  32  nonce of the most recent qualifying hash.
- found_cnt  output  CNT_W  number of qualifying hashes, saturating.

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE, hash_ready=1.
  - result_valid=0, result_meets=0.
  - found=0, golden_nonce=0, found_cnt=0.
  - Internal latches and index cleared.
- Constant: NCHUNK = 256/CHUNK_W.
- IDLE:
  - hash_ready=1.
  - On hash_valid && hash_ready: latch hash_in, target_in and nonce_in, set idx=NCHUNK-1, go to CMP.
  - target_in is sampled only at accept, so it may change mid-compare without effect.
- CMP:
  - hash_ready=0. Each cycle, compare unsigned chunk [idx*CHUNK_W +: CHUNK_W] of the latched hash vs the latched target.
  - hash chunk < target chunk: meets=1, go to DONE.
  - hash chunk > target chunk: meets=0, go to DONE.
  - Equal and idx==0: meets=1 (equality qualifies), go to DONE.
  - Equal and idx>0: idx-1, stay in CMP.
- DONE:
  - result_valid=1 and result_meets driven for exactly this cycle, hash_ready=0, then go to IDLE.
  - If meets=1: golden_nonce<=latched nonce, found<=1, found_cnt increments and saturates at all-ones.
- Latency: accept in cycle 0, with k chunks examined (1..NCHUNK):
  - result_valid in cycle k+1.
  - hash_ready high again in cycle k+2.
  - Minimum throughput: one hash per NCHUNK+2 cycles.
- result_meets holds its value between pulses; only sample it with result_valid.
- clear_found:
  - Clears found only; golden_nonce and found_cnt are retained.
  - If asserted in the same cycle as a DONE with meets=1, the find wins: found stays 1 and golden_nonce updates.
- hash_valid outside IDLE is ignored; upstream must hold data until it sees hash_ready.
- rst_n asserted mid-CMP aborts the comparison. No result_valid is produced and all outputs return to reset values.

Optional Feature:
- HASH_BYTE_SWAP_EN defined:
  - hash_in is byte-reversed at accept (byte 0 becomes byte 31), matching the Bitcoin little-endian digest order.
  - target_in is not swapped.
- Undefined: hash_in is used as-is. No other differences.

Decomposition:
- Shared package/header holds:
  - HASH_W=256, NONCE_W=32.
  - State encodings IDLE/CMP/DONE.
  - A byte-reverse function reused by the hash core.
- Natural sub-module: chunk_cmp, a combinational unsigned CHUNK_W compare returning lt/gt/eq. Instantiated once, with operands selected by idx.

Test Plan:
- target=0x00000000_FFFF0000_0..0 (nBits 0x1d00ffff), hash=0x..01, nonce=0x12345678 -> chunk 6 decides; result_valid 3 cycles after accept; meets=1, found=1, golden_nonce=0x12345678, found_cnt=1.
- Same target, hash=all ones -> chunk 7 decides; result_valid 2 cycles after accept; meets=0; found/golden_nonce unchanged.
- hash==target exactly -> 8 chunks; result_valid 9 cycles after accept; meets=1. Then hash=target+1 -> meets=0.
- Back-to-back hash_valid held high -> hash_ready low during CMP/DONE; second accept exactly one cycle after the first result_valid; target_in changed mid-compare has no effect.
- clear_found coincident with DONE meets=1 -> found stays 1 and golden_nonce updates; clear_found alone the next cycle -> found=0, found_cnt retained. Drive found_cnt to 0xFFFF, find once more -> stays at 0xFFFF.
- rst_n low during CMP -> no result_valid pulse, all outputs at reset values. With HASH_BYTE_SWAP_EN: hash_in=0x01 in byte 31, target all ones except top byte 0x00 -> meets=1.

Source files
------------

// File: rtl/hash_target_check_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hash_target_check_pkg
// Brief    : Shared widths, compare FSM encodings and a digest byte-reverse helper.
// Revision : 1.0
// ---------------------------------------------------------------------------
package hash_target_check_pkg;

  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte 0 becomes byte HASH_W/8-1; the hash core reuses this for digest order.
  function automatic logic [HASH_W-1:0] byte_reverse(input logic [HASH_W-1:0] din);
    logic [HASH_W-1:0] dout;
    for (int i = 0; i < HASH_W/8; i++) begin
      dout[i*8 +: 8] = din[(HASH_W/8-1-i)*8 +: 8];
    end
    return dout;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hash_target_check_chunk_cmp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hash_target_check_chunk_cmp
// Brief    : Combinational unsigned magnitude compare of one CHUNK_W slice.
// Revision : 1.0
// ---------------------------------------------------------------------------
module hash_target_check_chunk_cmp #(
  parameter int CHUNK_W = 32
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  output logic               lt,
  output logic               gt,
  output logic               eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/hash_target_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hash_target_check
// Brief    : Iterative MSB-first hash <= target check with golden-nonce latch.
//            Define HASH_BYTE_SWAP_EN to byte-reverse hash_in at accept.
// Revision : 1.0
// ---------------------------------------------------------------------------
module hash_target_check
  import hash_target_check_pkg::*;
#(
  parameter int CHUNK_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hash_valid,
  output logic               hash_ready,
  input  logic [HASH_W-1:0]  hash_in,
  input  logic [NONCE_W-1:0] nonce_in,
  input  logic [HASH_W-1:0]  target_in,
  input  logic               clear_found,
  output logic               result_valid,
  output logic               result_meets,
  output logic               found,
  output logic [NONCE_W-1:0] golden_nonce,
  output logic [CNT_W-1:0]   found_cnt
);

  localparam int NCHUNK = HASH_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  if ((HASH_W % CHUNK_W) != 0) begin : g_chunk_w_check
    $error("hash_target_check: CHUNK_W must divide 256");
  end

  state_e               state_q, state_d;
  logic [HASH_W-1:0]    hash_q, hash_d;
  logic [HASH_W-1:0]    target_q, target_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 meets_q, meets_d;
  logic                 result_valid_q, result_valid_d;
  logic                 hash_ready_q, hash_ready_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   golden_q, golden_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [HASH_W-1:0]    hash_acc;
  logic [CHUNK_W-1:0]   hash_chunk   [NCHUNK];
  logic [CHUNK_W-1:0]   target_chunk [NCHUNK];
  logic                 chunk_lt, chunk_gt, chunk_eq;

`ifdef HASH_BYTE_SWAP_EN
  assign hash_acc = byte_reverse(hash_in);
`else
  assign hash_acc = hash_in;
`endif

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign hash_chunk[gi]   = hash_q[gi*CHUNK_W +: CHUNK_W];
    assign target_chunk[gi] = target_q[gi*CHUNK_W +: CHUNK_W];
  end

  hash_target_check_chunk_cmp #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_cmp (
    .a  (hash_chunk[idx_q]),
    .b  (target_chunk[idx_q]),
    .lt (chunk_lt),
    .gt (chunk_gt),
    .eq (chunk_eq)
  );

  always_comb begin
    state_d        = state_q;
    hash_d         = hash_q;
    target_d       = target_q;
    nonce_d        = nonce_q;
    idx_d          = idx_q;
    meets_d        = meets_q;
    result_valid_d = 1'b0;
    found_d        = found_q;
    golden_d       = golden_q;
    cnt_d          = cnt_q;

    // A find in DONE below overrides a coincident clear.
    if (clear_found) begin
      found_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (hash_valid && hash_ready_q) begin
          hash_d   = hash_acc;
          target_d = target_in;
          nonce_d  = nonce_in;
          idx_d    = IDX_TOP;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (chunk_lt || (chunk_eq && (idx_q == '0))) begin
          meets_d        = 1'b1;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end else if (chunk_gt) begin
          meets_d        = 1'b0;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (meets_q) begin
          found_d  = 1'b1;
          golden_d = nonce_q;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    hash_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      hash_q         <= '0;
      target_q       <= '0;
      nonce_q        <= '0;
      idx_q          <= '0;
      meets_q        <= 1'b0;
      result_valid_q <= 1'b0;
      hash_ready_q   <= 1'b1;
      found_q        <= 1'b0;
      golden_q       <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      hash_q         <= hash_d;
      target_q       <= target_d;
      nonce_q        <= nonce_d;
      idx_q          <= idx_d;
      meets_q        <= meets_d;
      result_valid_q <= result_valid_d;
      hash_ready_q   <= hash_ready_d;
      found_q        <= found_d;
      golden_q       <= golden_d;
      cnt_q          <= cnt_d;
    end
  end

  assign hash_ready   = hash_ready_q;
  assign result_valid = result_valid_q;
  assign result_meets = meets_q;
  assign found        = found_q;
  assign golden_nonce = golden_q;
  assign found_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_target_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_hash_target_check
// Brief    : Scoreboard bench for hash_target_check (directed vectors).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_hash_target_check;

  localparam int CHUNK_W = 32;
  localparam int CNT_W   = 4;
  localparam logic [255:0] T_1D = {32'h0, 32'hFFFF0000, 192'h0};

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               hash_valid = 1'b0;
  logic               clear_found = 1'b0;
  logic [255:0]       hash_in = '0;
  logic [255:0]       target_in = '0;
  logic [31:0]        nonce_in = '0;
  logic               hash_ready;
  logic               result_valid;
  logic               result_meets;
  logic               found;
  logic [31:0]        golden_nonce;
  logic [CNT_W-1:0]   found_cnt;

  hash_target_check #(
    .CHUNK_W (CHUNK_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hash_valid   (hash_valid),
    .hash_ready   (hash_ready),
    .hash_in      (hash_in),
    .nonce_in     (nonce_in),
    .target_in    (target_in),
    .clear_found  (clear_found),
    .result_valid (result_valid),
    .result_meets (result_meets),
    .found        (found),
    .golden_nonce (golden_nonce),
    .found_cnt    (found_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic             meets;
    int               lat;
    int               c0;
    logic             found;
    logic [31:0]      golden;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sbq[$];
  exp_t             mi;
  int               errors = 0;
  int               checks = 0;
  int               pulses = 0;
  logic             m_found = 1'b0;
  logic [31:0]      m_golden = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] bswap(input logic [255:0] d);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = d[(31-i)*8 +: 8];
    return r;
  endfunction

  // Vectors are written as numeric hash values; in swap builds the bus carries
  // the byte-reversed digest so the same expectations hold.
  function automatic logic [255:0] prep(input logic [255:0] h);
`ifdef HASH_BYTE_SWAP_EN
    return bswap(h);
`else
    return h;
`endif
  endfunction

  task automatic send(input logic [255:0] h, input logic [255:0] t, input logic [31:0] n,
                      input logic m, input int k, input bit raw, output int c0);
    exp_t e;
    hash_in    = raw ? h : prep(h);
    target_in  = t;
    nonce_in   = n;
    hash_valid = 1'b1;
    for (int g = 0; g < 40 && !hash_ready; g++) @(negedge clk);
    c0 = cyc;
    if (!hash_ready) begin
      chk("accept_timeout", 256'(1'b0), 256'(1'b1));
      hash_valid = 1'b0;
      return;
    end
    if (m) begin
      m_found  = 1'b1;
      m_golden = n;
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
    e.meets  = m;
    e.lat    = k + 1;
    e.c0     = cyc;
    e.found  = m_found;
    e.golden = m_golden;
    e.cnt    = m_cnt;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int g = 0; g < 200 && sbq.size() != 0; g++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares the pulse, then the sticky state one cycle later.
  always begin
    @(negedge clk);
    if (rst_n && result_valid) begin
      pulses++;
      if (sbq.size() == 0) begin
        chk("unexpected_result", 256'(1'b1), 256'(1'b0));
      end else begin
        mi = sbq.pop_front();
        chk("result_meets", 256'(result_meets), 256'(mi.meets));
        chk("latency", 256'(cyc - mi.c0), 256'(mi.lat));
        chk("ready_low_in_done", 256'(hash_ready), 256'(1'b0));
        @(negedge clk);
        chk("result_valid_one_cycle", 256'(result_valid), 256'(1'b0));
        chk("found", 256'(found), 256'(mi.found));
        chk("golden_nonce", 256'(golden_nonce), 256'(mi.golden));
        chk("found_cnt", 256'(found_cnt), 256'(mi.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, p0;
    logic [255:0] tplus;
    tplus = T_1D + 256'd1;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hash_ready", 256'(hash_ready), 256'(1'b1));
    chk("rst_result_valid", 256'(result_valid), 256'(1'b0));
    chk("rst_result_meets", 256'(result_meets), 256'(1'b0));
    chk("rst_found", 256'(found), 256'(1'b0));
    chk("rst_golden", 256'(golden_nonce), 256'(32'h0));
    chk("rst_cnt", 256'(found_cnt), 256'(4'h0));
    rst_n = 1'b1;
    @(negedge clk);

    // Chunk 6 decides (k=2), meets.
    send(256'h1, T_1D, 32'h12345678, 1'b1, 2, 1'b0, c0);
    hash_valid = 1'b0;
    drain();
    // Chunk 7 decides (k=1), fails.
    send({256{1'b1}}, T_1D, 32'h0BAD0001, 1'b0, 1, 1'b0, c0);
    hash_valid = 1'b0;
    drain();
    // Exact equality walks all 8 chunks and qualifies; target+1 does not.
    send(T_1D, T_1D, 32'hAAAA0001, 1'b1, 8, 1'b0, c0);
    hash_valid = 1'b0;
    drain();
    send(tplus, T_1D, 32'hAAAA0002, 1'b0, 8, 1'b0, c0);
    hash_valid = 1'b0;
    drain();

    // Back-to-back with target_in switched to 0 while the first is comparing.
    send(256'h1, T_1D, 32'hB0B00001, 1'b1, 2, 1'b0, c0);
    send(256'h1, 256'h0, 32'hB0B00002, 1'b0, 8, 1'b0, c1);
    hash_valid = 1'b0;
    chk("b2b_accept_gap", 256'(c1 - c0), 256'(4));
    drain();

    // clear_found coincident with a qualifying DONE, then alone.
    send(256'h0, {256{1'b1}}, 32'hC1EA0001, 1'b1, 1, 1'b0, c0);
    hash_valid = 1'b0;
    @(negedge clk);
    clear_found = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_found = 1'b0;
    m_found = 1'b0;
    chk("clear_found_alone", 256'(found), 256'(1'b0));
    chk("clear_keeps_golden", 256'(golden_nonce), 256'(32'hC1EA0001));
    chk("clear_keeps_cnt", 256'(found_cnt), 256'(m_cnt));
    drain();

    // Reset in the middle of an 8-chunk compare.
    hash_in    = prep(T_1D);
    target_in  = T_1D;
    nonce_in   = 32'hDEAD0001;
    hash_valid = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    chk("ready_low_in_cmp", 256'(hash_ready), 256'(1'b0));
    repeat (2) @(negedge clk);
    p0 = pulses;
    rst_n = 1'b0;
    #1;
    chk("abort_hash_ready", 256'(hash_ready), 256'(1'b1));
    chk("abort_result_meets", 256'(result_meets), 256'(1'b0));
    chk("abort_found", 256'(found), 256'(1'b0));
    chk("abort_golden", 256'(golden_nonce), 256'(32'h0));
    chk("abort_cnt", 256'(found_cnt), 256'(4'h0));
    m_found  = 1'b0;
    m_golden = '0;
    m_cnt    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_pulse", 256'(pulses), 256'(p0));

    // Saturation of found_cnt (narrow counter in this bench).
    for (int i = 1; i <= 17; i++) begin
      send(256'h0, {256{1'b1}}, 32'h5A700000 + i, 1'b1, 1, 1'b0, c0);
    end
    hash_valid = 1'b0;
    drain();
    chk("cnt_saturated", 256'(found_cnt), 256'(4'hF));

    // Raw little-endian digest: 0x01 in byte 31; qualifies only when swapped.
`ifdef HASH_BYTE_SWAP_EN
    send({8'h01, 248'h0}, {8'h00, {248{1'b1}}}, 32'h5AAB0001, 1'b1, 1, 1'b1, c0);
`else
    send({8'h01, 248'h0}, {8'h00, {248{1'b1}}}, 32'h5AAB0001, 1'b0, 1, 1'b1, c0);
`endif
    hash_valid = 1'b0;
    drain();

    chk("scoreboard_empty", 256'(sbq.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
